// File: rtl/decoder_round_issuer.sv
// rtl/decoder_round_issuer.sv - issues one measurement round at a time to the decoder and returns a tagged result record
// Optional statistics block enabled by defining ROUND_LATENCY_STATS_EN.
module decoder_round_issuer #(
    parameter int MEAS_WIDTH              = 64,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int ROUND_ID_WIDTH          = 8,
    parameter int TIMEOUT_CYCLES          = 100000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [MEAS_WIDTH-1:0]              s_meas,
    output logic                               new_round_start,
    output logic [MEAS_WIDTH-1:0]              meas_out,
    input  logic                               result_valid,
    input  logic                               deadlock,
    input  logic                               final_cardinality,
    input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    input  logic [31:0]                        cycle_counter,
    output logic                               r_valid,
    input  logic                               r_ready,
    output logic [ROUND_ID_WIDTH-1:0]          r_round_id,
    output logic [1:0]                         r_status,
    output logic                               r_cardinality,
    output logic [ITERATION_COUNTER_WIDTH-1:0] r_iterations,
    output logic [31:0]                        r_cycles,
    output logic                               halted,
    output logic [31:0]                        stat_max_cycles,
    output logic [15:0]                        stat_deadlocks
);

    localparam int TCW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_DEADLOCK = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT,
        S_EMIT,
        S_HALT
    } state_t;

    state_t                    state;
    logic [TCW-1:0]            timeout_cnt;
    logic [ROUND_ID_WIDTH-1:0] round_id;
    logic                      wait_hit;
    logic [1:0]                wait_status;
    logic                      emit_fire;

    assign s_ready   = (state == S_IDLE);
    assign emit_fire = (state == S_EMIT) && r_ready;

    // Deadlock outranks a result, and a result outranks the timeout threshold.
    always_comb begin
        wait_hit    = 1'b0;
        wait_status = ST_OK;
        if (deadlock) begin
            wait_hit    = 1'b1;
            wait_status = ST_DEADLOCK;
        end else if (result_valid) begin
            wait_hit    = 1'b1;
            wait_status = ST_OK;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
            wait_hit    = 1'b1;
            wait_status = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            timeout_cnt     <= '0;
            round_id        <= '0;
            new_round_start <= 1'b0;
            meas_out        <= '0;
            r_valid         <= 1'b0;
            r_round_id      <= '0;
            r_status        <= ST_OK;
            r_cardinality   <= 1'b0;
            r_iterations    <= '0;
            r_cycles        <= '0;
            halted          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_valid) begin
                        meas_out        <= s_meas;
                        new_round_start <= 1'b1;
                        state           <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    new_round_start <= 1'b0;
                    state           <= S_ARM;
                end
                // Blanking cycle: decoder flags still reflect the previous round here.
                S_ARM: begin
                    timeout_cnt <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_hit) begin
                        r_valid       <= 1'b1;
                        r_round_id    <= round_id;
                        r_status      <= wait_status;
                        r_cardinality <= final_cardinality;
                        r_iterations  <= iteration_counter;
                        r_cycles      <= cycle_counter;
                        state         <= S_EMIT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (r_ready) begin
                        r_valid  <= 1'b0;
                        round_id <= round_id + 1'b1;
                        if (r_status == ST_TIMEOUT) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ROUND_LATENCY_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_max_cycles <= '0;
            stat_deadlocks  <= '0;
        end else if (emit_fire) begin
            if ((r_status == ST_OK) && (r_cycles > stat_max_cycles)) begin
                stat_max_cycles <= r_cycles;
            end
            if ((r_status == ST_DEADLOCK) && (stat_deadlocks != 16'hFFFF)) begin
                stat_deadlocks <= stat_deadlocks + 16'd1;
            end
        end
    end
`else
    assign stat_max_cycles = '0;
    assign stat_deadlocks  = '0;
`endif

endmodule
